// File: rtl/i2si_ctrl_pkg.sv
// i2si_pkg: shared types for the I2S input controller slice.
//   I2SI_WORD_W        - audio word width
//   i2si_ctrl_state_t  - controller sequencing states
//   i2si_frame_t       - one stereo pair as stored in the frame FIFO
//   i2si_active()      - true in the states where the deserializer runs
package i2si_pkg;

  localparam int unsigned I2SI_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN
  } i2si_ctrl_state_t;

  typedef struct packed {
    logic [I2SI_WORD_W-1:0] lft;
    logic [I2SI_WORD_W-1:0] rgt;
  } i2si_frame_t;

  function automatic logic i2si_active(input i2si_ctrl_state_t s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/i2si_ctrl_if.sv
// i2si_ctrl_if: downstream frame read port (valid/ready).
//   rd_vld  - head frame valid          (master -> slave)
//   rd_lft  - head left word            (master -> slave)
//   rd_rgt  - head right word           (master -> slave)
//   rd_rdy  - consumer accepts the head (slave -> master)
interface i2si_ctrl_if;
  import i2si_pkg::*;

  logic                   rd_vld;
  logic                   rd_rdy;
  logic [I2SI_WORD_W-1:0] rd_lft;
  logic [I2SI_WORD_W-1:0] rd_rgt;

  modport master (output rd_vld, output rd_lft, output rd_rgt, input rd_rdy);
  modport slave  (input rd_vld, input rd_lft, input rd_rgt, output rd_rdy);

endinterface

// File: rtl/i2si_ctrl_frame_fifo.sv
// i2si_frame_fifo: synchronous FIFO of i2si_frame_t, DEPTH a power of two.
//   clk, rst  - clock, asynchronous active-high reset (flushes contents)
//   push      - write request; ignored when full unless popping this cycle
//   wr_data   - frame to write
//   pop       - read request; ignored when empty
//   rd_data   - head entry (reads as zero after reset)
//   full      - DEPTH entries held
//   empty     - no entries held
//   level     - number of entries held
module i2si_frame_fifo
  import i2si_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  i2si_frame_t            wr_data,
  input  logic                   pop,
  output i2si_frame_t            rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  i2si_frame_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2si_ctrl.sv
// i2si_ctrl: sequencing controller for the I2S input deserializer.
// Aligns des_en to a left-channel frame start (falling word select), buffers
// completed stereo pairs in a frame FIFO and presents them on a valid/ready
// read port. Reports FIFO overflow and loss of serial clock.
//   clk, rst     - clock, asynchronous active-high reset
//   rf_i2si_en   - register-file enable level
//   rf_flag_clr  - pulse clearing ovf / sck_lost (and drop_cnt)
//   i2si_ws      - pad word select, asynchronous to clk
//   i2si_lft/rgt - deserializer words, valid with i2si_xfc
//   i2si_xfc     - stereo pair complete pulse
//   des_en       - deserializer enable (RUN/DRAIN)
//   rd           - read port: rd_vld, rd_rdy, rd_lft, rd_rgt
//   fifo_lvl     - occupied FIFO entries
//   ovf          - sticky: frame dropped on full FIFO
//   sck_lost     - sticky: no i2si_xfc for TMO_CYC cycles while running
//   busy         - controller not IDLE
// Optional (macro I2SI_CTRL_STATS_EN):
//   frm_cnt      - accepted frames, wrapping
//   drop_cnt     - dropped frames, saturating
module i2si_ctrl
  import i2si_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TMO_CYC    = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rf_i2si_en,
  input  logic                         rf_flag_clr,
  input  logic                         i2si_ws,
  input  logic [I2SI_WORD_W-1:0]       i2si_lft,
  input  logic [I2SI_WORD_W-1:0]       i2si_rgt,
  input  logic                         i2si_xfc,
  output logic                         des_en,
  i2si_ctrl_if.master                  rd,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_lvl,
  output logic                         ovf,
  output logic                         sck_lost,
  output logic                         busy
`ifdef I2SI_CTRL_STATS_EN
  ,
  output logic [15:0]                  frm_cnt,
  output logic [7:0]                   drop_cnt
`endif
);

  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  i2si_ctrl_state_t state;
  i2si_ctrl_state_t next_state;

  logic          ws_s1;
  logic          ws_s2;
  logic          ws_h;
  logic          ws_fall;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          sck_set;
  logic          des_en_d;

  logic          push_req;
  logic          pop_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;
  i2si_frame_t   wr_frame;
  i2si_frame_t   head;

  // Word-select synchronizer plus history flop. Reset to 0 so a pad held
  // low at reset release cannot look like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_s1 <= 1'b0;
      ws_s2 <= 1'b0;
      ws_h  <= 1'b0;
    end else begin
      ws_s1 <= i2si_ws;
      ws_s2 <= ws_s1;
      ws_h  <= ws_s2;
    end
  end

  assign ws_fall = ~ws_s2 & ws_h;

  // A pair completing on the last count still counts as serial clock present.
  assign tmo_hit = i2si_active(state) & ~i2si_xfc & (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    sck_set    = 1'b0;
    case (state)
      IDLE: begin
        if (rf_i2si_en) next_state = ARM;
      end
      ARM: begin
        if (!rf_i2si_en)  next_state = IDLE;
        else if (ws_fall) next_state = RUN;
      end
      RUN: begin
        if (!rf_i2si_en) begin
          next_state = DRAIN;
        end else if (tmo_hit) begin
          next_state = ARM;
          sck_set    = 1'b1;
        end
      end
      DRAIN: begin
        if (i2si_xfc) begin
          next_state = IDLE;
        end else if (tmo_hit) begin
          next_state = IDLE;
          sck_set    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // des_en is registered from the next state so it tracks RUN/DRAIN exactly.
  always_comb begin
    des_en_d = i2si_active(next_state);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      des_en <= 1'b0;
    end else begin
      des_en <= des_en_d;
    end
  end

  // Counter restarts on every entry to RUN or DRAIN, including RUN -> DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (i2si_active(next_state) && (next_state != state)) begin
      tmo_cnt <= '0;
    end else if (i2si_active(state)) begin
      if (i2si_xfc) tmo_cnt <= '0;
      else          tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign push_req     = i2si_xfc & des_en;
  assign pop_req      = rd.rd_rdy & ~fifo_empty;
  assign drop         = push_req & fifo_full & ~pop_req;
  assign wr_frame.lft = i2si_lft;
  assign wr_frame.rgt = i2si_rgt;

  i2si_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .wr_data (wr_frame),
    .pop     (pop_req),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_lvl)
  );

  assign rd.rd_vld = ~fifo_empty;
  assign rd.rd_lft = head.lft;
  assign rd.rd_rgt = head.rgt;

  // Sticky flags: a set event on the same cycle as rf_flag_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      sck_lost <= 1'b0;
    end else begin
      if (drop)             ovf <= 1'b1;
      else if (rf_flag_clr) ovf <= 1'b0;
      if (sck_set)          sck_lost <= 1'b1;
      else if (rf_flag_clr) sck_lost <= 1'b0;
    end
  end

`ifdef I2SI_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_req && !drop) frm_cnt <= frm_cnt + 16'd1;
      if (drop) begin
        if (rf_flag_clr)          drop_cnt <= 8'd1;
        else if (drop_cnt != '1)  drop_cnt <= drop_cnt + 8'd1;
      end else if (rf_flag_clr) begin
        drop_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2si_ctrl.sv
module tb_i2si_ctrl;
  import i2si_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 4096;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rf_i2si_en = 1'b0;
  logic          rf_flag_clr = 1'b0;
  logic          i2si_ws = 1'b1;
  logic [15:0]   i2si_lft = '0;
  logic [15:0]   i2si_rgt = '0;
  logic          i2si_xfc = 1'b0;
  logic          des_en;
  logic [LW-1:0] fifo_lvl;
  logic          ovf;
  logic          sck_lost;
  logic          busy;
`ifdef I2SI_CTRL_STATS_EN
  logic [15:0]   frm_cnt;
  logic [7:0]    drop_cnt;
`endif

  i2si_ctrl_if bus ();

  i2si_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .TMO_CYC    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rf_i2si_en  (rf_i2si_en),
    .rf_flag_clr (rf_flag_clr),
    .i2si_ws     (i2si_ws),
    .i2si_lft    (i2si_lft),
    .i2si_rgt    (i2si_rgt),
    .i2si_xfc    (i2si_xfc),
    .des_en      (des_en),
    .rd          (bus),
    .fifo_lvl    (fifo_lvl),
    .ovf         (ovf),
    .sck_lost    (sck_lost),
    .busy        (busy)
`ifdef I2SI_CTRL_STATS_EN
    ,
    .frm_cnt     (frm_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frames as {lft, rgt}, sticky ovf, enable as expected.
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_des_en = 1'b0;
  int          m_drop = 0;
  int          m_frm = 0;

  // Apply the current inputs to the model, then advance one clock.
  task automatic tick();
    bit was_full, pop, push;
    was_full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && (bus.rd_rdy === 1'b1);
    push = (i2si_xfc === 1'b1) && m_des_en && !rst;
    if (rf_flag_clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (was_full && !pop) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end else begin
        mq.push_back({i2si_lft, i2si_rgt});
        m_frm = (m_frm + 1) % 65536;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({des_en, bus.rd_vld, ovf, sck_lost, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got des_en/vld/ovf/sck/busy=%b want 00000",
               {des_en, bus.rd_vld, ovf, sck_lost, busy});
    end
    n_checks++;
    if ({fifo_lvl, bus.rd_lft, bus.rd_rgt} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got lvl=%0d lft=%h rgt=%h want 0", fifo_lvl, bus.rd_lft, bus.rd_rgt);
    end
`ifdef I2SI_CTRL_STATS_EN
    n_checks++;
    if ({frm_cnt, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: got frm=%0d drop=%0d want 0", frm_cnt, drop_cnt);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    rf_i2si_en = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_busy: got %b want 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (des_en !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_no_fall_des_en: cycle %0d got %b want 0", i, des_en);
      end
    end
    i2si_ws = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (des_en !== (e == 3)) begin
        n_fail++;
        $display("FAIL enable_des_en_latency: edge %0d got %b want %b", e, des_en, e == 3);
      end
    end
    m_des_en = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] frames [3];
    frames[0] = 32'h1478_A3B9;
    frames[1] = 32'hCDD7_BABA;
    frames[2] = 32'h4444_AAAA;
    bus.rd_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      {i2si_lft, i2si_rgt} = frames[f];
      i2si_xfc = 1'b1;
      tick();
      i2si_xfc = 1'b0;
      n_checks++;
      if (bus.rd_vld !== 1'b1 || {bus.rd_lft, bus.rd_rgt} !== frames[f] || fifo_lvl !== LW'(1)) begin
        n_fail++;
        $display("FAIL stream_head[%0d]: got vld=%b data=%h lvl=%0d want 1 %h 1",
                 f, bus.rd_vld, {bus.rd_lft, bus.rd_rgt}, fifo_lvl, frames[f]);
      end
      tick();
      n_checks++;
      if (bus.rd_vld !== 1'b0 || fifo_lvl !== '0) begin
        n_fail++;
        $display("FAIL stream_popped[%0d]: got vld=%b lvl=%0d want 0 0", f, bus.rd_vld, fifo_lvl);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      i2si_lft   = 16'($urandom);
      i2si_rgt   = 16'($urandom);
      i2si_xfc   = ($urandom_range(0, 1) == 1);
      bus.rd_rdy = ($urandom_range(0, 2) == 0);
      tick();
      n_checks++;
      if (fifo_lvl !== LW'(mq.size()) || bus.rd_vld !== (mq.size() != 0) || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL random_state[%0d]: got lvl=%0d vld=%b ovf=%b want %0d %b %b",
                 c, fifo_lvl, bus.rd_vld, ovf, mq.size(), mq.size() != 0, m_ovf);
      end
      if (mq.size() != 0) begin
        n_checks++;
        if ({bus.rd_lft, bus.rd_rgt} !== mq[0]) begin
          n_fail++;
          $display("FAIL random_head[%0d]: got %h want %h", c, {bus.rd_lft, bus.rd_rgt}, mq[0]);
        end
      end
    end
    i2si_xfc   = 1'b0;
    bus.rd_rdy = 1'b1;
    repeat (DEPTH + 1) tick();
    n_checks++;
    if (fifo_lvl !== '0) begin
      n_fail++;
      $display("FAIL random_drain: got lvl=%0d want 0", fifo_lvl);
    end
    rf_flag_clr = 1'b1;
    tick();
    rf_flag_clr = 1'b0;
    bus.rd_rdy  = 1'b0;
  endtask

  task automatic test_overflow();
    bus.rd_rdy = 1'b0;
    for (int f = 0; f < 5; f++) begin
      i2si_lft = 16'($urandom);
      i2si_rgt = 16'($urandom);
      i2si_xfc = 1'b1;
      tick();
      i2si_xfc = 1'b0;
      tick();
    end
    n_checks++;
    if (fifo_lvl !== LW'(DEPTH) || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full: got lvl=%0d ovf=%b want %0d 1", fifo_lvl, ovf, DEPTH);
    end
`ifdef I2SI_CTRL_STATS_EN
    n_checks++;
    if (drop_cnt !== 8'(m_drop) || frm_cnt !== 16'(m_frm)) begin
      n_fail++;
      $display("FAIL ovf_stats: got drop=%0d frm=%0d want %0d %0d", drop_cnt, frm_cnt, m_drop, m_frm);
    end
`endif
    rf_flag_clr = 1'b1;
    tick();
    rf_flag_clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want 0", ovf);
    end
    // Full FIFO, push and pop together.
    i2si_lft = 16'($urandom);
    i2si_rgt = 16'($urandom);
    i2si_xfc = 1'b1;
    bus.rd_rdy = 1'b1;
    tick();
    i2si_xfc = 1'b0;
    bus.rd_rdy = 1'b0;
    n_checks++;
    if (fifo_lvl !== LW'(DEPTH) || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_push_pop: got lvl=%0d ovf=%b want %0d 0", fifo_lvl, ovf, DEPTH);
    end
    // Drop coincident with a clear: the set wins.
    i2si_xfc = 1'b1;
    rf_flag_clr = 1'b1;
    tick();
    i2si_xfc = 1'b0;
    rf_flag_clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b want 1", ovf);
    end
`ifdef I2SI_CTRL_STATS_EN
    n_checks++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_cnt_set_wins: got %0d want 1", drop_cnt);
    end
`endif
    bus.rd_rdy = 1'b1;
    for (int k = 0; k < 2 * DEPTH && mq.size() != 0; k++) begin
      n_checks++;
      if (bus.rd_vld !== 1'b1 || {bus.rd_lft, bus.rd_rgt} !== mq[0]) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: got vld=%b data=%h want 1 %h", k, bus.rd_vld, {bus.rd_lft, bus.rd_rgt}, mq[0]);
      end
      tick();
    end
    n_checks++;
    if (fifo_lvl !== '0 || bus.rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drained: got lvl=%0d vld=%b want 0 0", fifo_lvl, bus.rd_vld);
    end
    rf_flag_clr = 1'b1;
    tick();
    rf_flag_clr = 1'b0;
    bus.rd_rdy  = 1'b0;
  endtask

  task automatic test_drain();
    logic [31:0] last;
    rf_i2si_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (des_en !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_hold[%0d]: got des_en=%b busy=%b want 1 1", c, des_en, busy);
      end
    end
    last = $urandom;
    {i2si_lft, i2si_rgt} = last;
    i2si_xfc = 1'b1;
    tick();
    i2si_xfc = 1'b0;
    m_des_en = 1'b0;
    n_checks++;
    if (des_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_exit: got des_en=%b busy=%b want 0 0", des_en, busy);
    end
    n_checks++;
    if (fifo_lvl !== LW'(1) || {bus.rd_lft, bus.rd_rgt} !== last) begin
      n_fail++;
      $display("FAIL drain_frame: got lvl=%0d data=%h want 1 %h", fifo_lvl, {bus.rd_lft, bus.rd_rgt}, last);
    end
    // A pair completing while idle is ignored.
    i2si_lft = 16'hDEAD;
    i2si_xfc = 1'b1;
    tick();
    i2si_xfc = 1'b0;
    tick();
    n_checks++;
    if (fifo_lvl !== LW'(1) || {bus.rd_lft, bus.rd_rgt} !== last) begin
      n_fail++;
      $display("FAIL idle_xfc_ignored: got lvl=%0d data=%h want 1 %h", fifo_lvl, {bus.rd_lft, bus.rd_rgt}, last);
    end
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0;
    n_checks++;
    if (fifo_lvl !== '0) begin
      n_fail++;
      $display("FAIL idle_drain: got lvl=%0d want 0", fifo_lvl);
    end
  endtask

  // Stimulus only: present a ws high-then-low sequence while enabled.
  task automatic enter_run();
    rf_i2si_en = 1'b1;
    i2si_ws = 1'b1;
    repeat (3) tick();
    i2si_ws = 1'b0;
    repeat (3) tick();
    m_des_en = 1'b1;
  endtask

  task automatic test_timeout();
    enter_run();
    n_checks++;
    if (des_en !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_entry: got des_en=%b want 1", des_en);
    end
    repeat (TMO - 1) tick();
    n_checks++;
    if (sck_lost !== 1'b0 || des_en !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_early: got sck_lost=%b des_en=%b want 0 1", sck_lost, des_en);
    end
    tick();
    m_des_en = 1'b0;
    n_checks++;
    if (sck_lost !== 1'b1 || des_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_fire: got sck_lost=%b des_en=%b busy=%b want 1 0 1", sck_lost, des_en, busy);
    end
    rf_flag_clr = 1'b1;
    tick();
    rf_flag_clr = 1'b0;
    n_checks++;
    if (sck_lost !== 1'b0 || des_en !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: got sck_lost=%b des_en=%b want 0 0", sck_lost, des_en);
    end
    // Re-entry restarts the count; a pair mid-way restarts it again.
    enter_run();
    repeat (2000) tick();
    bus.rd_rdy = 1'b1;
    i2si_xfc = 1'b1;
    tick();
    i2si_xfc = 1'b0;
    repeat (3000) tick();
    bus.rd_rdy = 1'b0;
    n_checks++;
    if (sck_lost !== 1'b0 || des_en !== 1'b1 || fifo_lvl !== '0) begin
      n_fail++;
      $display("FAIL tmo_restart: got sck_lost=%b des_en=%b lvl=%0d want 0 1 0", sck_lost, des_en, fifo_lvl);
    end
  endtask

  task automatic test_reset_midrun();
    bus.rd_rdy = 1'b0;
    for (int f = 0; f < 3; f++) begin
      i2si_lft = 16'($urandom);
      i2si_rgt = 16'($urandom) | 16'h0001;
      i2si_xfc = 1'b1;
      tick();
      i2si_xfc = 1'b0;
      tick();
    end
    n_checks++;
    if (fifo_lvl !== LW'(3) || des_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got lvl=%0d des_en=%b want 3 1", fifo_lvl, des_en);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({des_en, bus.rd_vld, ovf, sck_lost, busy} !== 5'b0 || {fifo_lvl, bus.rd_lft, bus.rd_rgt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got flags=%b lvl=%0d lft=%h rgt=%h want 0",
               {des_en, bus.rd_vld, ovf, sck_lost, busy}, fifo_lvl, bus.rd_lft, bus.rd_rgt);
    end
    mq.delete();
    m_des_en = 1'b0;
    m_ovf = 1'b0;
    rf_i2si_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bus.rd_rdy = 1'b0;
    test_reset();
    test_enable();
    test_stream();
    test_random();
    test_overflow();
    test_drain();
    test_timeout();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
